pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the in-order RISC pipeline.
- Drives the `freeze` and `update_pc` inputs of every pipeline register.
- Drives the 34-bit forwarding bus (MuxData) of the decode→execute register.
- Detects RAW hazards against the EX and WB stages and selects operand forwarding. It also inserts load-use stalls, sequences branch flushes and holds the pipeline in a halt state.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl_fwd_match.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the
// pipeline registers it drives.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      FLUSH  = 2'd2,
      HALT   = 2'd3
   } state_e;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_A    = 2'b01;
   localparam logic [1:0] FWD_B    = 2'b10;

   // Opcodes the pipeline registers inject on flush (NOP) and on halt (NPHLT).
   localparam logic [5:0] OP_NOP   = 6'h00;
   localparam logic [5:0] OP_NPHLT = 6'h3F;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline status in, hazard control out. The pipeline side is the master,
// the hazard controller is the slave.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_BITS = 3,
   parameter int DATA_W   = 32
);
   logic                dec_valid;
   logic [REG_BITS-1:0] dec_src_a;
   logic [REG_BITS-1:0] dec_src_b;
   logic                dec_use_a;
   logic                dec_use_b;
   logic                ex_valid;
   logic                ex_wr_en;
   logic [REG_BITS-1:0] ex_dst;
   logic                ex_is_load;
   logic [DATA_W-1:0]   ex_result;
   logic                wb_valid;
   logic                wb_wr_en;
   logic [REG_BITS-1:0] wb_dst;
   logic [DATA_W-1:0]   wb_result;
   logic                br_taken;
   logic                halt_req;
   logic                resume;
   logic                freeze;
   logic                update_pc;
   logic [DATA_W+1:0]   mux_data;
   logic                halted;
   logic [15:0]         stall_cnt;

   modport master (
      output dec_valid, dec_src_a, dec_src_b, dec_use_a, dec_use_b,
      output ex_valid, ex_wr_en, ex_dst, ex_is_load, ex_result,
      output wb_valid, wb_wr_en, wb_dst, wb_result,
      output br_taken, halt_req, resume,
      input  freeze, update_pc, mux_data, halted, stall_cnt
   );

   modport slave (
      input  dec_valid, dec_src_a, dec_src_b, dec_use_a, dec_use_b,
      input  ex_valid, ex_wr_en, ex_dst, ex_is_load, ex_result,
      input  wb_valid, wb_wr_en, wb_dst, wb_result,
      input  br_taken, halt_req, resume,
      output freeze, update_pc, mux_data, halted, stall_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_match.sv
// Per-operand comparator: does this decode source need data from EX or WB,
// and which value wins (EX is newer, so it takes priority).
module fwd_match
   import pipe_pkg::*;
#(
   parameter int REG_BITS    = 3,
   parameter int DATA_W      = 32,
   parameter int ZERO_REG_HW = 1
) (
   input  logic                dec_valid,
   input  logic                use_src,
   input  logic [REG_BITS-1:0] src,
   input  logic                ex_valid,
   input  logic                ex_wr_en,
   input  logic [REG_BITS-1:0] ex_dst,
   input  logic [DATA_W-1:0]   ex_result,
   input  logic                wb_valid,
   input  logic                wb_wr_en,
   input  logic [REG_BITS-1:0] wb_dst,
   input  logic [DATA_W-1:0]   wb_result,
   output logic                hit_ex,
   output logic                hit_wb,
   output logic [DATA_W-1:0]   value
);

   logic src_live;

   // Hit detection per stage and EX-over-WB value selection.
   always_comb begin
      src_live = dec_valid && use_src && ((src != '0) || (ZERO_REG_HW == 0));
      hit_ex   = src_live && ex_valid && ex_wr_en && (ex_dst == src);
      hit_wb   = src_live && wb_valid && wb_wr_en && (wb_dst == src);
      value    = hit_ex ? ex_result : (hit_wb ? wb_result : '0);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: forwarding select, load-use stalls,
// branch flush sequencing and halt hold for the in-order pipeline.
//
// state  | meaning
// RUN    | normal issue; forwarding, dual-match and load-use detect active
// LSTALL | extra load-use freeze cycles after the detect cycle
// FLUSH  | extra update_pc cycles after a taken branch
// HALT   | pipeline held until resume
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_BITS     = 3,
   parameter int DATA_W       = 32,
   parameter int LOAD_STALL   = 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int ZERO_REG_HW  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam int               CNT_W       = 3;
   localparam logic [CNT_W-1:0] LSTALL_LOAD = CNT_W'(LOAD_STALL - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               halt_pend_q, halt_pend_d;
   logic [15:0]        stall_cnt_q, stall_cnt_d;

   logic               hit_ex_a, hit_wb_a, hit_ex_b, hit_wb_b;
   logic [DATA_W-1:0]  val_a, val_b;
   logic               fwd_a, fwd_b, load_use;
   logic               freeze_c, upd_c, freeze;
   logic [DATA_W+1:0]  mux_c;

   fwd_match #(.REG_BITS(REG_BITS), .DATA_W(DATA_W), .ZERO_REG_HW(ZERO_REG_HW)) u_match_a (
      .dec_valid (bus.dec_valid),
      .use_src   (bus.dec_use_a),
      .src       (bus.dec_src_a),
      .ex_valid  (bus.ex_valid),
      .ex_wr_en  (bus.ex_wr_en),
      .ex_dst    (bus.ex_dst),
      .ex_result (bus.ex_result),
      .wb_valid  (bus.wb_valid),
      .wb_wr_en  (bus.wb_wr_en),
      .wb_dst    (bus.wb_dst),
      .wb_result (bus.wb_result),
      .hit_ex    (hit_ex_a),
      .hit_wb    (hit_wb_a),
      .value     (val_a)
   );

   fwd_match #(.REG_BITS(REG_BITS), .DATA_W(DATA_W), .ZERO_REG_HW(ZERO_REG_HW)) u_match_b (
      .dec_valid (bus.dec_valid),
      .use_src   (bus.dec_use_b),
      .src       (bus.dec_src_b),
      .ex_valid  (bus.ex_valid),
      .ex_wr_en  (bus.ex_wr_en),
      .ex_dst    (bus.ex_dst),
      .ex_result (bus.ex_result),
      .wb_valid  (bus.wb_valid),
      .wb_wr_en  (bus.wb_wr_en),
      .wb_dst    (bus.wb_dst),
      .wb_result (bus.wb_result),
      .hit_ex    (hit_ex_b),
      .hit_wb    (hit_wb_b),
      .value     (val_b)
   );

   assign fwd_a    = hit_ex_a | hit_wb_a;
   assign fwd_b    = hit_ex_b | hit_wb_b;
   assign load_use = bus.ex_is_load & (hit_ex_a | hit_ex_b);

   // Next state and combinational outputs; branch outranks everything but HALT.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      halt_pend_d = halt_pend_q;
      freeze_c    = 1'b0;
      upd_c       = 1'b0;
      mux_c       = '0;
      if ((state_q != HALT) && bus.br_taken) begin
         upd_c       = 1'b1;
         // A halt retiring alongside the branch is kept, not dropped.
         halt_pend_d = halt_pend_q | bus.halt_req;
         if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
         end else begin
            state_d     = halt_pend_d ? HALT : RUN;
            halt_pend_d = 1'b0;
            cnt_d       = '0;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (bus.halt_req) begin
                  state_d = HALT;
               end else if (load_use) begin
                  freeze_c = 1'b1;
                  if (LOAD_STALL > 1) begin
                     state_d = LSTALL;
                     cnt_d   = LSTALL_LOAD;
                  end
               end else if (fwd_a && fwd_b) begin
                  freeze_c = 1'b1;
               end else if (fwd_a) begin
                  mux_c = {FWD_A, val_a};
               end else if (fwd_b) begin
                  mux_c = {FWD_B, val_b};
               end
            end
            LSTALL: begin
               freeze_c = 1'b1;
               if (bus.halt_req) begin
                  state_d = HALT;
                  cnt_d   = '0;
               end else if (cnt_q <= CNT_ONE) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            FLUSH: begin
               upd_c       = 1'b1;
               halt_pend_d = halt_pend_q | bus.halt_req;
               if (cnt_q <= CNT_ONE) begin
                  state_d     = halt_pend_d ? HALT : RUN;
                  halt_pend_d = 1'b0;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            HALT: begin
               freeze_c = 1'b1;
               if (bus.resume) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Outputs are forced to their idle values while reset is held.
   assign freeze        = rst_n & freeze_c;
   assign bus.freeze    = freeze;
   assign bus.update_pc = rst_n & upd_c;
   assign bus.mux_data  = rst_n ? mux_c : '0;
   assign bus.halted    = (state_q == HALT);
   assign bus.stall_cnt = stall_cnt_q;

   // Saturating count of frozen cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (freeze && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // State, sequencing counter, halt-pending and stall counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         halt_pend_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         halt_pend_q <= halt_pend_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (LOAD_STALL=2, FLUSH_CYCLES=2).
// Each cycle's expected outputs are queued when stimulus is applied and
// popped/compared at the following falling edge.
module tb_pipeline_hazard_ctrl;
   import pipe_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_BITS(3), .DATA_W(32)) bus ();

   pipeline_hazard_ctrl #(
      .REG_BITS(3), .DATA_W(32), .LOAD_STALL(2), .FLUSH_CYCLES(2), .ZERO_REG_HW(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [52:0] v;   // {freeze, update_pc, halted, mux_data[33:0], stall_cnt[15:0]}
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [52:0] obs;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_scnt = 16'd0;

   task automatic idle();
      bus.dec_valid = 0; bus.dec_src_a = 0; bus.dec_src_b = 0; bus.dec_use_a = 0; bus.dec_use_b = 0;
      bus.ex_valid = 0; bus.ex_wr_en = 0; bus.ex_dst = 0; bus.ex_is_load = 0; bus.ex_result = 0;
      bus.wb_valid = 0; bus.wb_wr_en = 0; bus.wb_dst = 0; bus.wb_result = 0;
      bus.br_taken = 0; bus.halt_req = 0; bus.resume = 0;
   endtask

   task automatic dec_rd(input logic [2:0] a, input logic ua, input logic [2:0] b, input logic ub);
      bus.dec_valid = 1; bus.dec_src_a = a; bus.dec_use_a = ua; bus.dec_src_b = b; bus.dec_use_b = ub;
   endtask

   task automatic ex_wr(input logic [2:0] d, input logic ld, input logic [31:0] r);
      bus.ex_valid = 1; bus.ex_wr_en = 1; bus.ex_dst = d; bus.ex_is_load = ld; bus.ex_result = r;
   endtask

   task automatic wb_wr(input logic [2:0] d, input logic [31:0] r);
      bus.wb_valid = 1; bus.wb_wr_en = 1; bus.wb_dst = d; bus.wb_result = r;
   endtask

   task automatic push_exp(input string n, input logic f, input logic u, input logic h,
                           input logic [33:0] m);
      exp_t x;
      x.name = n;
      x.v    = {f, u, h, m, exp_scnt};
      sb.push_back(x);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         idle();
         case (c)
            0: begin
               dec_rd(3'd3, 1, 3'd0, 0); ex_wr(3'd3, 0, 32'hAA); bus.br_taken = 1;
               push_exp("reset_held", 0, 0, 0, 34'h0);
            end
            default: begin
               rst_n = 1'b1;
               push_exp("reset_released", 0, 0, 0, 34'h0);
            end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         obs = {bus.freeze, bus.update_pc, bus.halted, bus.mux_data, bus.stall_cnt};
         n_checks++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d, expected frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d",
                     e.name, obs[52], obs[51], obs[50], obs[49:16], obs[15:0],
                     e.v[52], e.v[51], e.v[50], e.v[49:16], e.v[15:0]);
         end
         if (e.v[52] && exp_scnt != 16'hFFFF) exp_scnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      for (int c = 0; c < 3; c++) begin
         idle();
         case (c)
            0: begin dec_rd(3'd5, 1, 3'd0, 0); ex_wr(3'd5, 1, 32'hDEAD); push_exp("load_detect", 1, 0, 0, 34'h0); end
            1: begin dec_rd(3'd5, 1, 3'd0, 0); ex_wr(3'd5, 1, 32'hDEAD); push_exp("load_lstall", 1, 0, 0, 34'h0); end
            default: begin dec_rd(3'd5, 1, 3'd0, 0); wb_wr(3'd5, 32'h55); push_exp("load_wb_fwd", 0, 0, 0, {2'b01, 32'h55}); end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         obs = {bus.freeze, bus.update_pc, bus.halted, bus.mux_data, bus.stall_cnt};
         n_checks++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d, expected frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d",
                     e.name, obs[52], obs[51], obs[50], obs[49:16], obs[15:0],
                     e.v[52], e.v[51], e.v[50], e.v[49:16], e.v[15:0]);
         end
         if (e.v[52] && exp_scnt != 16'hFFFF) exp_scnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_forwarding();
      for (int c = 0; c < 8; c++) begin
         idle();
         case (c)
            0: begin dec_rd(3'd3, 1, 3'd0, 0); ex_wr(3'd3, 0, 32'hAA); push_exp("fwd_ex_a", 0, 0, 0, {2'b01, 32'hAA}); end
            1: begin dec_rd(3'd0, 0, 3'd3, 1); ex_wr(3'd3, 0, 32'hAA); push_exp("fwd_ex_b", 0, 0, 0, {2'b10, 32'hAA}); end
            2: begin dec_rd(3'd0, 0, 3'd2, 1); ex_wr(3'd2, 0, 32'h11); wb_wr(3'd2, 32'h22);
                     push_exp("fwd_ex_over_wb", 0, 0, 0, {2'b10, 32'h11}); end
            3: begin dec_rd(3'd6, 1, 3'd0, 0); wb_wr(3'd6, 32'h22); push_exp("fwd_wb_a", 0, 0, 0, {2'b01, 32'h22}); end
            4: begin dec_rd(3'd4, 1, 3'd4, 1); ex_wr(3'd5, 0, 32'h77); wb_wr(3'd6, 32'h88);
                     push_exp("fwd_no_match", 0, 0, 0, 34'h0); end
            5: begin dec_rd(3'd3, 0, 3'd0, 0); ex_wr(3'd3, 0, 32'h99); push_exp("fwd_use_off", 0, 0, 0, 34'h0); end
            6: begin dec_rd(3'd3, 1, 3'd0, 0); ex_wr(3'd3, 0, 32'h99); bus.ex_wr_en = 0; wb_wr(3'd3, 32'h66);
                     push_exp("fwd_ex_nowrite", 0, 0, 0, {2'b01, 32'h66}); end
            default: begin dec_rd(3'd3, 1, 3'd0, 0); bus.dec_valid = 0; ex_wr(3'd3, 0, 32'h99);
                     push_exp("fwd_dec_invalid", 0, 0, 0, 34'h0); end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         obs = {bus.freeze, bus.update_pc, bus.halted, bus.mux_data, bus.stall_cnt};
         n_checks++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d, expected frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d",
                     e.name, obs[52], obs[51], obs[50], obs[49:16], obs[15:0],
                     e.v[52], e.v[51], e.v[50], e.v[49:16], e.v[15:0]);
         end
         if (e.v[52] && exp_scnt != 16'hFFFF) exp_scnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_dual_and_zero();
      for (int c = 0; c < 3; c++) begin
         idle();
         case (c)
            0: begin dec_rd(3'd1, 1, 3'd2, 1); ex_wr(3'd1, 0, 32'h10); wb_wr(3'd2, 32'h20);
                     push_exp("dual_match", 1, 0, 0, 34'h0); end
            1: begin push_exp("dual_cleared", 0, 0, 0, 34'h0); end
            default: begin dec_rd(3'd0, 1, 3'd0, 1); ex_wr(3'd0, 0, 32'h1234_5678); wb_wr(3'd0, 32'h9);
                     push_exp("zero_reg", 0, 0, 0, 34'h0); end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         obs = {bus.freeze, bus.update_pc, bus.halted, bus.mux_data, bus.stall_cnt};
         n_checks++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d, expected frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d",
                     e.name, obs[52], obs[51], obs[50], obs[49:16], obs[15:0],
                     e.v[52], e.v[51], e.v[50], e.v[49:16], e.v[15:0]);
         end
         if (e.v[52] && exp_scnt != 16'hFFFF) exp_scnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_in_lstall();
      for (int c = 0; c < 4; c++) begin
         idle();
         case (c)
            0: begin dec_rd(3'd5, 1, 3'd0, 0); ex_wr(3'd5, 1, 32'hDEAD); push_exp("br_detect", 1, 0, 0, 34'h0); end
            1: begin dec_rd(3'd5, 1, 3'd0, 0); ex_wr(3'd5, 1, 32'hDEAD); bus.br_taken = 1;
                     push_exp("br_cancel_lstall", 0, 1, 0, 34'h0); end
            2: begin dec_rd(3'd5, 1, 3'd0, 0); ex_wr(3'd5, 1, 32'hDEAD); push_exp("br_flush", 0, 1, 0, 34'h0); end
            default: begin dec_rd(3'd3, 1, 3'd0, 0); ex_wr(3'd3, 0, 32'h33);
                     push_exp("br_back_to_run", 0, 0, 0, {2'b01, 32'h33}); end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         obs = {bus.freeze, bus.update_pc, bus.halted, bus.mux_data, bus.stall_cnt};
         n_checks++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d, expected frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d",
                     e.name, obs[52], obs[51], obs[50], obs[49:16], obs[15:0],
                     e.v[52], e.v[51], e.v[50], e.v[49:16], e.v[15:0]);
         end
         if (e.v[52] && exp_scnt != 16'hFFFF) exp_scnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt();
      for (int c = 0; c < 9; c++) begin
         idle();
         case (c)
            0: begin bus.br_taken = 1; push_exp("halt_br", 0, 1, 0, 34'h0); end
            1: begin bus.halt_req = 1; push_exp("halt_req_in_flush", 0, 1, 0, 34'h0); end
            2: begin bus.br_taken = 1; dec_rd(3'd3, 1, 3'd0, 0); ex_wr(3'd3, 0, 32'h44);
                     push_exp("halt_ignores_br", 1, 0, 1, 34'h0); end
            3: begin bus.resume = 1; push_exp("halt_resume_cycle", 1, 0, 1, 34'h0); end
            4: begin dec_rd(3'd3, 1, 3'd0, 0); ex_wr(3'd3, 0, 32'h44);
                     push_exp("halt_resumed_run", 0, 0, 0, {2'b01, 32'h44}); end
            5: begin bus.halt_req = 1; bus.resume = 1; push_exp("halt_and_resume_req", 0, 0, 0, 34'h0); end
            6: begin push_exp("halt_entered", 1, 0, 1, 34'h0); end
            7: begin bus.resume = 1; push_exp("halt_resume2", 1, 0, 1, 34'h0); end
            default: begin push_exp("halt_left", 0, 0, 0, 34'h0); end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         obs = {bus.freeze, bus.update_pc, bus.halted, bus.mux_data, bus.stall_cnt};
         n_checks++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d, expected frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d",
                     e.name, obs[52], obs[51], obs[50], obs[49:16], obs[15:0],
                     e.v[52], e.v[51], e.v[50], e.v[49:16], e.v[15:0]);
         end
         if (e.v[52] && exp_scnt != 16'hFFFF) exp_scnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_lstall();
      for (int c = 0; c < 3; c++) begin
         idle();
         case (c)
            0: begin dec_rd(3'd5, 1, 3'd0, 0); ex_wr(3'd5, 1, 32'hBEEF); push_exp("rst_detect", 1, 0, 0, 34'h0); end
            1: begin dec_rd(3'd5, 1, 3'd0, 0); ex_wr(3'd5, 1, 32'hBEEF); rst_n = 1'b0; exp_scnt = 16'd0;
                     push_exp("rst_mid_lstall", 0, 0, 0, 34'h0); end
            default: begin rst_n = 1'b1; push_exp("rst_after", 0, 0, 0, 34'h0); end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         obs = {bus.freeze, bus.update_pc, bus.halted, bus.mux_data, bus.stall_cnt};
         n_checks++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d, expected frz=%0b upc=%0b hlt=%0b mux=%h scnt=%0d",
                     e.name, obs[52], obs[51], obs[50], obs[49:16], obs[15:0],
                     e.v[52], e.v[51], e.v[50], e.v[49:16], e.v[15:0]);
         end
         if (e.v[52] && exp_scnt != 16'hFFFF) exp_scnt++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, expected finish before 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_forwarding();
      test_dual_and_zero();
      test_branch_in_lstall();
      test_halt();
      test_reset_mid_lstall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
